// File: rtl/attention_tile_sequencer.sv
// Job-level controller for a weight-stationary systolic array: accepts tile jobs,
// loads weights only when the resident tile differs, streams, then reports completion.
module attention_tile_sequencer #(
  parameter int N     = 4,
  parameter int ID_W  = 4,
  parameter int CNT_W = $clog2(3*N+3)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [ID_W-1:0]      job_weight_id,
  input  logic                 flush,
  output logic                 weight_load_enable,
  output logic [$clog2(N)-1:0] weight_row,
  output logic                 do_process,
  output logic [CNT_W-1:0]     stream_count,
  output logic                 capture_en,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [ID_W-1:0]      done_weight_id,
  output logic                 busy,
  output logic [15:0]          jobs_done
);
  localparam int ROW_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] LAST_PROC = CNT_W'(3*N+2);
  localparam logic [CNT_W-1:0] CAP_LO    = CNT_W'(N+2);
  localparam logic [CNT_W-1:0] CAP_HI    = CNT_W'(3*N);

  typedef enum logic [1:0] {IDLE, LOAD, PROC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [15:0]       jobs_done_q, jobs_done_d;

  logic              job_ready_c, wle_c, proc_c, cap_c, done_valid_c;
  logic [ROW_W-1:0]  row_c;
  logic [CNT_W-1:0]  sc_c;
  logic [ID_W-1:0]   dwid_c;

  // Handshakes: a job transfers on an edge where job_valid && job_ready; a completion
  // transfers on an edge where done_valid && done_ready. done_valid holds until taken.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    jobs_done_d  = jobs_done_q;
    job_ready_c  = 1'b0;
    wle_c        = 1'b0;
    row_c        = '0;
    proc_c       = 1'b0;
    sc_c         = '0;
    cap_c        = 1'b0;
    done_valid_c = 1'b0;
    dwid_c       = '0;
    case (state_q)
      IDLE: begin
        job_ready_c = 1'b1;
        if (job_valid) begin
          id_d  = job_weight_id;
          cnt_d = '0;
          // A flush on the accept edge invalidates residency, so it cannot be a hit.
          if (res_valid_q && !flush && (job_weight_id == res_id_q)) state_d = PROC;
          else                                                      state_d = LOAD;
        end
      end
      LOAD: begin
        wle_c = 1'b1;
        row_c = cnt_q[ROW_W-1:0];
        if (cnt_q == LAST_ROW) begin
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = PROC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PROC: begin
        proc_c = 1'b1;
        sc_c   = cnt_q;
        cap_c  = (cnt_q >= CAP_LO) && (cnt_q <= CAP_HI);
        if (cnt_q == LAST_PROC) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_valid_c = 1'b1;
        dwid_c       = id_q;
        if (done_ready) begin
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  // Outputs are forced low while reset is asserted, before the first reset edge too.
  assign job_ready          = reset & job_ready_c;
  assign weight_load_enable = reset & wle_c;
  assign weight_row         = reset ? row_c : '0;
  assign do_process         = reset & proc_c;
  assign stream_count       = reset ? sc_c : '0;
  assign capture_en         = reset & cap_c;
  assign done_valid         = reset & done_valid_c;
  assign done_weight_id     = reset ? dwid_c : '0;
  assign busy               = reset & (state_q != IDLE);
  assign jobs_done          = reset ? jobs_done_q : '0;
endmodule
